// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - instruction/data memory handshake between control unit and memory
interface multicycle_control_unit_if;
   logic [31:0] instr;
   logic        mem_ready;
   logic        mem_req;

   modport master (
      input  instr,
      input  mem_ready,
      output mem_req
   );

   modport slave (
      output instr,
      output mem_ready,
      input  mem_req
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle RV32I control FSM with memory handshake timeout trap
module multicycle_control_unit #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 8
) (
   input  logic                             clk,
   input  logic                             rst_n,
   multicycle_control_unit_if.master        mem,
   input  logic                             br_taken,
   input  logic                             trap_clr,
   output logic                             IRWr,
   output logic                             PCWr,
   output logic                             PCSrc,
   output logic                             RUWr,
   output logic [3:0]                       ALUOp,
   output logic [2:0]                       ImmSrc,
   output logic                             ALUASrc,
   output logic                             ALUBSrc,
   output logic                             DMWr,
   output logic [2:0]                       DMCtrl,
   output logic [4:0]                       BrOp,
   output logic [1:0]                       RUDataWrSrc,
   output logic [2:0]                       state,
   output logic                             illegal
);

   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_MEMORY    = 3'd3,
      S_WRITEBACK = 3'd4,
      S_TRAP      = 3'd7
   } state_t;

   typedef enum logic [3:0] {
      C_NONE, C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_LUI, C_AUIPC, C_JAL, C_JALR
   } class_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   state_t           cur;
   state_t           nxt;
   class_t           cls;
   logic [6:0]       opcode;
   logic [2:0]       f3;
   logic [6:0]       f7;
   logic [CNT_W-1:0] cnt;
   logic             waiting;
   logic             timeout;
   logic             unused_bits;

   // Operand/immediate bits of the instruction word belong to the datapath, not here.
   assign unused_bits = ^{mem.instr[24:15], mem.instr[11:7], f7[6], f7[4:0]};

   // A memory access is stalling when requested but not yet acknowledged.
   assign waiting = ((cur == S_FETCH) || (cur == S_MEMORY)) && !mem.mem_ready;
   assign timeout = waiting && (cnt == CNT_LAST);

   assign state   = cur;
   assign illegal = (cur == S_TRAP);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur <= S_FETCH;
      end else begin
         cur <= nxt;
      end
   end

   // Capture the decode fields once per instruction, when the fetch completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opcode <= '0;
         f3     <= '0;
         f7     <= '0;
      end else if ((cur == S_FETCH) && mem.mem_ready) begin
         opcode <= mem.instr[6:0];
         f3     <= mem.instr[14:12];
         f7     <= mem.instr[31:25];
      end
   end

   // Wait counter: counts stalled cycles, restarts whenever the state moves.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (nxt != cur) begin
         cnt <= '0;
      end else if (waiting) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Classify the latched opcode.
   always_comb begin
      cls = C_NONE;
      case (opcode)
         7'b0110011: cls = C_R;
         7'b0010011: cls = C_I;
         7'b0000011: cls = C_LOAD;
         7'b0100011: cls = C_STORE;
         7'b1100011: cls = C_BRANCH;
         7'b0110111: cls = C_LUI;
         7'b0010111: cls = C_AUIPC;
         7'b1101111: cls = C_JAL;
         7'b1100111: cls = C_JALR;
         default:    cls = C_NONE;
      endcase
   end

   // Datapath controls, driven only while an instruction is in flight.
   always_comb begin
      ALUOp       = 4'b0000;
      ImmSrc      = 3'b000;
      ALUASrc     = 1'b0;
      ALUBSrc     = 1'b0;
      DMCtrl      = 3'b000;
      BrOp        = 5'b00000;
      RUDataWrSrc = 2'b00;
      if ((cur == S_DECODE) || (cur == S_EXECUTE) || (cur == S_MEMORY) || (cur == S_WRITEBACK)) begin
         case (cls)
            C_R: begin
               ALUOp = {f7[5], f3};
            end
            C_I: begin
               ALUOp   = {(f3 == 3'b101) ? f7[5] : 1'b0, f3};
               ALUBSrc = 1'b1;
            end
            C_LOAD: begin
               ALUBSrc     = 1'b1;
               DMCtrl      = f3;
               RUDataWrSrc = 2'b01;
            end
            C_STORE: begin
               ImmSrc  = 3'b001;
               ALUBSrc = 1'b1;
               DMCtrl  = f3;
            end
            C_BRANCH: begin
               ImmSrc  = 3'b101;
               ALUASrc = 1'b1;
               ALUBSrc = 1'b1;
               BrOp    = {2'b01, f3};
            end
            C_LUI: begin
               ImmSrc  = 3'b010;
               ALUOp   = 4'b1111;
               ALUBSrc = 1'b1;
            end
            C_AUIPC: begin
               ImmSrc  = 3'b010;
               ALUASrc = 1'b1;
               ALUBSrc = 1'b1;
            end
            C_JAL: begin
               ImmSrc      = 3'b110;
               ALUASrc     = 1'b1;
               ALUBSrc     = 1'b1;
               BrOp        = 5'b00100;
               RUDataWrSrc = 2'b10;
            end
            C_JALR: begin
               ALUBSrc     = 1'b1;
               BrOp        = 5'b00100;
               RUDataWrSrc = 2'b10;
            end
            default: begin
            end
         endcase
      end
   end

   // Next state and strobes; fetch-side outputs are masked while reset is held.
   always_comb begin
      nxt         = cur;
      mem.mem_req = 1'b0;
      IRWr        = 1'b0;
      PCWr        = 1'b0;
      PCSrc       = 1'b0;
      RUWr        = 1'b0;
      DMWr        = 1'b0;
      case (cur)
         S_FETCH: begin
            mem.mem_req = rst_n;
            if (mem.mem_ready) begin
               IRWr = rst_n;
               nxt  = S_DECODE;
            end else if (timeout) begin
               nxt = S_TRAP;
            end
         end
         S_DECODE: begin
            nxt = (cls == C_NONE) ? S_TRAP : S_EXECUTE;
         end
         S_EXECUTE: begin
            if ((cls == C_LOAD) || (cls == C_STORE)) begin
               nxt = S_MEMORY;
            end else if (cls == C_BRANCH) begin
               PCWr  = 1'b1;
               PCSrc = br_taken;
               nxt   = S_FETCH;
            end else begin
               nxt = S_WRITEBACK;
            end
         end
         S_MEMORY: begin
            mem.mem_req = 1'b1;
            DMWr        = (cls == C_STORE);
            if (mem.mem_ready) begin
               if (cls == C_STORE) begin
                  PCWr = 1'b1;
                  nxt  = S_FETCH;
               end else begin
                  nxt = S_WRITEBACK;
               end
            end else if (timeout) begin
               nxt = S_TRAP;
            end
         end
         S_WRITEBACK: begin
            RUWr  = 1'b1;
            PCWr  = 1'b1;
            PCSrc = (cls == C_JAL) || (cls == C_JALR);
            nxt   = S_FETCH;
         end
         S_TRAP: begin
            if (trap_clr) begin
               nxt = S_FETCH;
            end
         end
         default: begin
            nxt = S_FETCH;
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;
   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       br_taken = 1'b0;
   logic       trap_clr = 1'b0;
   logic       IRWr, PCWr, PCSrc, RUWr, ALUASrc, ALUBSrc, DMWr, illegal;
   logic [3:0] ALUOp;
   logic [2:0] ImmSrc, DMCtrl, state;
   logic [4:0] BrOp;
   logic [1:0] RUDataWrSrc;

   multicycle_control_unit_if mif();

   multicycle_control_unit #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mem         (mif),
      .br_taken    (br_taken),
      .trap_clr    (trap_clr),
      .IRWr        (IRWr),
      .PCWr        (PCWr),
      .PCSrc       (PCSrc),
      .RUWr        (RUWr),
      .ALUOp       (ALUOp),
      .ImmSrc      (ImmSrc),
      .ALUASrc     (ALUASrc),
      .ALUBSrc     (ALUBSrc),
      .DMWr        (DMWr),
      .DMCtrl      (DMCtrl),
      .BrOp        (BrOp),
      .RUDataWrSrc (RUDataWrSrc),
      .state       (state),
      .illegal     (illegal)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] aluop;
      logic [2:0] imm;
      logic       asrc;
      logic       bsrc;
      logic [2:0] dm;
      logic [4:0] br;
      logic [1:0] wsrc;
   } ctrl_t;

   typedef struct {
      logic [31:0] ins;
      ctrl_t       c;
      int          cyc;
   } vec_t;

   typedef enum int {K_ILL, K_R, K_I, K_LD, K_ST, K_BR, K_LUI, K_AUIPC, K_JAL, K_JALR} kind_t;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [28:0] all_outs();
      return {mif.mem_req, IRWr, PCWr, PCSrc, RUWr, ALUOp, ImmSrc, ALUASrc, ALUBSrc,
              DMWr, DMCtrl, BrOp, RUDataWrSrc, state, illegal};
   endfunction

   function automatic ctrl_t dut_ctrl();
      return {ALUOp, ImmSrc, ALUASrc, ALUBSrc, DMCtrl, BrOp, RUDataWrSrc};
   endfunction

   function automatic kind_t kind_of(input logic [6:0] op);
      case (op)
         7'h33:   return K_R;
         7'h13:   return K_I;
         7'h03:   return K_LD;
         7'h23:   return K_ST;
         7'h63:   return K_BR;
         7'h37:   return K_LUI;
         7'h17:   return K_AUIPC;
         7'h6F:   return K_JAL;
         7'h67:   return K_JALR;
         default: return K_ILL;
      endcase
   endfunction

   // Reference control values from the instruction-class rules.
   function automatic ctrl_t model_ctrl(input logic [31:0] ins);
      ctrl_t      c   = '0;
      logic [2:0] f3  = ins[14:12];
      logic       f75 = ins[30];
      case (kind_of(ins[6:0]))
         K_R:     c.aluop = {f75, f3};
         K_I:     begin c.aluop = {(f3 == 3'b101) && f75, f3}; c.bsrc = 1'b1; end
         K_LD:    begin c.bsrc = 1'b1; c.dm = f3; c.wsrc = 2'b01; end
         K_ST:    begin c.imm = 3'd1; c.bsrc = 1'b1; c.dm = f3; end
         K_BR:    begin c.imm = 3'd5; c.asrc = 1'b1; c.bsrc = 1'b1; c.br = {2'b01, f3}; end
         K_LUI:   begin c.imm = 3'd2; c.aluop = 4'hF; c.bsrc = 1'b1; end
         K_AUIPC: begin c.imm = 3'd2; c.asrc = 1'b1; c.bsrc = 1'b1; end
         K_JAL:   begin c.imm = 3'd6; c.asrc = 1'b1; c.bsrc = 1'b1; c.br = 5'd4; c.wsrc = 2'b10; end
         K_JALR:  begin c.bsrc = 1'b1; c.br = 5'd4; c.wsrc = 2'b10; end
         default: begin end
      endcase
      return c;
   endfunction

   function automatic vec_t mk(input logic [31:0] ins, input logic [3:0] a, input logic [2:0] im,
                               input logic as, input logic bs, input logic [2:0] dm,
                               input logic [4:0] br, input logic [1:0] ws, input int cyc);
      vec_t v;
      v.ins = ins;
      v.c   = {a, im, as, bs, dm, br, ws};
      v.cyc = cyc;
      return v;
   endfunction

   // Run one instruction with the given memory waits, checking every cycle against
   // the expected state walk; returns cycles until retirement (or until TRAP).
   task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                            input bit taken, input ctrl_t ec, output int lat);
      kind_t k = kind_of(ins[6:0]);
      int    seq[$];
      bit    rdy[$];
      int    n_ir = 0, n_pc = 0, n_ru = 0, n_dm = 0;
      logic  pcsrc_seen = 1'b0;
      bit    exp_ru;
      lat = -1;
      for (int i = 0; i < fw; i++) begin seq.push_back(0); rdy.push_back(1'b0); end
      seq.push_back(0); rdy.push_back(1'b1);
      seq.push_back(1); rdy.push_back(1'b0);
      if (k == K_ILL) begin
         seq.push_back(7); rdy.push_back(1'b0);
      end else begin
         seq.push_back(2); rdy.push_back(1'b0);
         if (k == K_LD || k == K_ST) begin
            for (int i = 0; i < mw; i++) begin seq.push_back(3); rdy.push_back(1'b0); end
            seq.push_back(3); rdy.push_back(1'b1);
         end
         if (k != K_BR && k != K_ST) begin seq.push_back(4); rdy.push_back(1'b0); end
      end
      for (int i = 0; i < seq.size(); i++) begin
         @(negedge clk);
         mif.instr     = ins;
         mif.mem_ready = rdy[i];
         br_taken      = taken;
         trap_clr      = 1'b0;
         #1;
         check($sformatf("state c%0d %h", i, ins), state, seq[i]);
         check($sformatf("mem_req c%0d %h", i, ins), mif.mem_req, (seq[i] == 0 || seq[i] == 3));
         if (seq[i] >= 1 && seq[i] <= 4)
            check($sformatf("ctrl c%0d %h", i, ins), dut_ctrl(), ec);
         if (seq[i] == 7) begin
            check($sformatf("illegal %h", ins), illegal, 1'b1);
            if (lat < 0) lat = i + 1;
         end
         if (IRWr === 1'b1) n_ir++;
         if (RUWr === 1'b1) n_ru++;
         if (DMWr === 1'b1) n_dm++;
         if (PCWr === 1'b1) begin n_pc++; pcsrc_seen = PCSrc; lat = i + 1; end
         @(posedge clk);
      end
      #1;
      exp_ru = (k != K_ILL) && (k != K_BR) && (k != K_ST);
      check($sformatf("n_IRWr %h", ins), n_ir, 1);
      check($sformatf("n_PCWr %h", ins), n_pc, (k == K_ILL) ? 0 : 1);
      check($sformatf("n_RUWr %h", ins), n_ru, exp_ru);
      check($sformatf("n_DMWr %h", ins), n_dm, (k == K_ST) ? mw + 1 : 0);
      if (k != K_ILL) begin
         check($sformatf("PCSrc %h", ins), pcsrc_seen,
               (k == K_BR) ? taken : (k == K_JAL || k == K_JALR));
         check($sformatf("end_state %h", ins), state, 3'd0);
      end else begin
         check($sformatf("trap_state %h", ins), state, 3'd7);
      end
   endtask

   // Hold TRAP a few cycles with no strobes, then release with trap_clr.
   task automatic trap_clear();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         mif.mem_ready = 1'b1;
         trap_clr      = 1'b0;
         #1;
         check("trap_hold", {state, illegal, mif.mem_req, IRWr, PCWr, RUWr, DMWr}, {3'd7, 1'b1, 5'b0});
      end
      @(negedge clk);
      mif.mem_ready = 1'b0;
      trap_clr      = 1'b1;
      @(posedge clk);
      #1;
      check("trap_clr", {state, illegal}, {3'd0, 1'b0});
      trap_clr = 1'b0;
   endtask

   task automatic step(input bit rdy);
      @(negedge clk);
      mif.mem_ready = rdy;
      #1;
   endtask

   // Count cycles spent in state st with the memory never answering.
   task automatic wait_count(input logic [2:0] st, output int n);
      n = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         mif.mem_ready = 1'b0;
         #1;
         if (state !== st) break;
         n++;
      end
   endtask

   initial begin
      vec_t        tbl[14];
      int          lat;
      int          n;
      logic [31:0] r;
      logic [31:0] ins;
      logic [6:0]  op;
      logic [6:0]  legal_ops[9];

      tbl[0]  = mk(32'h003100B3, 4'h0, 3'd0, 0, 0, 3'd0, 5'd0, 2'd0, 4); // add
      tbl[1]  = mk(32'h40B50533, 4'h8, 3'd0, 0, 0, 3'd0, 5'd0, 2'd0, 4); // sub
      tbl[2]  = mk(32'h40155513, 4'hD, 3'd0, 0, 1, 3'd0, 5'd0, 2'd0, 4); // srai
      tbl[3]  = mk(32'h40010093, 4'h0, 3'd0, 0, 1, 3'd0, 5'd0, 2'd0, 4); // addi, F7[5] ignored
      tbl[4]  = mk(32'h00012083, 4'h0, 3'd0, 0, 1, 3'd2, 5'd0, 2'd1, 5); // lw
      tbl[5]  = mk(32'h00014083, 4'h0, 3'd0, 0, 1, 3'd4, 5'd0, 2'd1, 5); // lbu
      tbl[6]  = mk(32'h00112023, 4'h0, 3'd1, 0, 1, 3'd2, 5'd0, 2'd0, 4); // sw
      tbl[7]  = mk(32'h00208463, 4'h0, 3'd5, 1, 1, 3'd0, 5'd8, 2'd0, 3); // beq
      tbl[8]  = mk(32'h00209463, 4'h0, 3'd5, 1, 1, 3'd0, 5'd9, 2'd0, 3); // bne
      tbl[9]  = mk(32'h123450B7, 4'hF, 3'd2, 0, 1, 3'd0, 5'd0, 2'd0, 4); // lui
      tbl[10] = mk(32'h00001097, 4'h0, 3'd2, 1, 1, 3'd0, 5'd0, 2'd0, 4); // auipc
      tbl[11] = mk(32'h008000EF, 4'h0, 3'd6, 1, 1, 3'd0, 5'd4, 2'd2, 4); // jal
      tbl[12] = mk(32'h000100E7, 4'h0, 3'd0, 0, 1, 3'd0, 5'd4, 2'd2, 4); // jalr
      tbl[13] = mk(32'h0000007F, 4'h0, 3'd0, 0, 0, 3'd0, 5'd0, 2'd0, 3); // illegal

      legal_ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};

      // Reset: everything quiet even with memory reporting ready.
      mif.instr     = 32'h003100B3;
      mif.mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_outs", all_outs(), 29'd0);
      @(negedge clk);
      rst_n         = 1'b1;
      mif.mem_ready = 1'b0;
      #1;
      check("post_reset_state", state, 3'd0);
      check("post_reset_req", mif.mem_req, 1'b1);

      // Zero-wait table.
      for (int i = 0; i < 14; i++) begin
         run_instr(tbl[i].ins, 0, 0, 1'b0, tbl[i].c, lat);
         check($sformatf("latency %h", tbl[i].ins), lat, tbl[i].cyc);
         if (kind_of(tbl[i].ins[6:0]) == K_ILL) trap_clear();
      end

      // Load with two wait cycles in MEMORY.
      run_instr(32'h00012083, 0, 2, 1'b0, tbl[4].c, lat);
      check("lw_wait_latency", lat, 7);
      // Taken branch.
      run_instr(32'h00208463, 0, 0, 1'b1, tbl[7].c, lat);
      check("beq_taken_latency", lat, 3);
      // Store with slow memory and slow fetch.
      run_instr(32'h00112023, 2, 3, 1'b0, tbl[6].c, lat);
      check("sw_wait_latency", lat, 9);

      // Fetch timeout.
      wait_count(3'd0, n);
      check("fetch_timeout_cycles", n, TO);
      check("fetch_timeout_trap", {state, illegal, mif.mem_req}, {3'd7, 1'b1, 1'b0});
      trap_clear();

      // Memory timeout on a load.
      mif.instr = 32'h00012083;
      step(1'b1);
      check("ld_fetch_irwr", IRWr, 1'b1);
      step(1'b0);
      step(1'b0);
      check("ld_exec_state", state, 3'd2);
      wait_count(3'd3, n);
      check("mem_timeout_cycles", n, TO);
      check("mem_timeout_trap", {state, illegal, RUWr, PCWr}, {3'd7, 1'b1, 2'b00});
      trap_clear();

      // Reset asserted while a store is in MEMORY.
      mif.instr = 32'h00112023;
      step(1'b1);
      step(1'b0);
      step(1'b0);
      step(1'b0);
      check("st_mem_dmwr", {state, DMWr, mif.mem_req}, {3'd3, 1'b1, 1'b1});
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_outs", all_outs(), 29'd0);
      @(negedge clk);
      rst_n         = 1'b1;
      mif.mem_ready = 1'b0;
      run_instr(32'h003100B3, 0, 0, 1'b0, tbl[0].c, lat);
      check("after_reset_latency", lat, 4);

      // Randomized instructions and memory timing against the reference model.
      for (int it = 0; it < 150; it++) begin
         r = $urandom();
         if ($urandom_range(0, 9) == 0) begin
            op = 7'h7F;
            for (int t = 0; t < 8; t++) begin
               op = 7'($urandom());
               if (kind_of(op) == K_ILL) break;
            end
            if (kind_of(op) != K_ILL) op = 7'h7F;
         end else begin
            op = legal_ops[$urandom_range(0, 8)];
         end
         ins = {r[31:7], op};
         run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                   model_ctrl(ins), lat);
         if (kind_of(op) == K_ILL) trap_clear();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
